id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
ID/EX pipeline stage for the 64-bit RISC-V pipeline. It sits directly downstream of the register file and decoder, and registers operands, immediate and control for the EX stage. It also contains:
- load-use hazard detection, which stalls ID and inserts a bubble;
- a WB→ID same-cycle bypass, which covers the register file's write-at-posedge and combinational-read timing;
- x0 zero-forcing, because the register file does not hardwire x0;
- a flush path for taken branches.

Parameters:
XLEN, 64, datapath width
CTRL_W, 8, width of opaque EX/MEM/WB control bundle carried through
CNT_W, 16, width of saturating stall/bubble counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  5  source register 1 index
id_rs2  in  5  source register 2 index
id_rd  in  5  destination index
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2
id_rdata1  in  XLEN  register file ReadData1
id_rdata2  in  XLEN  register file ReadData2
id_imm  in  XLEN  sign-extended immediate
id_ctrl  in  CTRL_W  control bundle
id_mem_read  in  1  instruction is a load
id_reg_write  in  1  instruction writes rd
wb_reg_write  in  1  WB writing register file this cycle
wb_rd  in  5  WB destination
wb_data  in  XLEN  WB write data
flush  in  1  squash instruction entering EX (taken branch)
stall_id  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_rs1  out  5  registered rs1 (for EX forwarding)
ex_rs2  out  5  registered rs2
ex_rd  out  5  registered rd
ex_op_a  out  XLEN  registered operand A
ex_op_b  out  XLEN  registered operand B
ex_imm  out  XLEN  registered immediate
ex_ctrl  out  CTRL_W  registered control
ex_mem_read  out  1  registered load flag
ex_reg_write  out  1  registered write flag
stall_count  out  CNT_W  saturating count of load-use stall cycles
flush_count  out  CNT_W  saturating count of flushed valid instructions

Behaviour:
Reset (synchronous):
- All ex_* outputs become 0, ex_valid becomes 0, and both counters become 0.
- A reset mid-operation discards the instruction in EX; the next cycle is a bubble.

Hazard detection (combinational):
- hz = id_valid & ex_valid & ex_mem_read & (ex_rd≠0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- stall_id = hz & ~flush & ~reset.

Operand select, A (B is identical using rs2/rdata2):
- If id_rs1==0, the operand is 0.
- Else if wb_reg_write & wb_rd==id_rs1, the operand is wb_data.
- Else the operand is id_rdata1.

Register update at posedge clk, in priority order:
1. reset: as above.
2. flush: ex_valid, ex_mem_read and ex_reg_write become 0; ex_ctrl becomes 0; the data fields are don't-care and are held. flush_count increments if id_valid.
3. hz: bubble. ex_valid, ex_mem_read and ex_reg_write become 0; ex_ctrl becomes 0. stall_count increments. The ID instruction is held upstream and re-presented next cycle.
4. Otherwise: load all fields from ID. ex_valid takes id_valid. When id_valid=0, ex_mem_read, ex_reg_write and ex_ctrl are forced to 0.

Latency and counters:
- Latency is 1 cycle ID→EX. A load-use pair costs exactly 1 bubble cycle, because after the bubble ex_valid=0 and hz clears.
- Counters saturate at all-ones and never wrap.

Simultaneous events:
- flush together with hz: flush wins, stall_id=0, and only flush_count increments.
- A WB write to x0 is never bypassed.

Test Plan:
- Reset and x0: with reset=1 for 2 cycles, all ex_* = 0 and counters = 0. Then issue id_rs1=0 with id_rdata1=0xDEAD → ex_op_a=0.
- Plain pass-through: id_valid=1, rs1=18 (rdata 10), rs2=20 (rdata 5), imm=−4, rd=21, reg_write=1 → the next cycle shows ex_op_a=10, ex_op_b=5, ex_imm=0xFFFF_FFFF_FFFF_FFFC, ex_rd=21, ex_valid=1, and stall_id=0 throughout.
- Load-use: a load with rd=5 is in EX; ID holds an add with rs2=5 and uses_rs2=1 → stall_id=1 for one cycle, followed by an ex_valid=0 bubble. The add enters EX the following cycle and stall_count=1.
- WB bypass: wb_reg_write=1, wb_rd=20, wb_data=99, id_rs2=20, id_rdata2=5 → ex_op_b=99. Repeat with wb_rd=0 and id_rs2=0 → ex_op_b=0.
- Flush and stall together: load-use condition present and flush=1 → stall_id=0, the next cycle has ex_valid=0, flush_count=1, stall_count unchanged.
- Saturation: force 2^CNT_W+3 load-use stalls → stall_count=0xFFFF. Then reset → 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB->ID bypass,
// x0 zero-forcing, branch flush and saturating stall/flush counters.
module id_ex_stage #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [4:0] REG_X0 = 5'd0;

    logic            hz;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    // Load-use hazard: the load in EX writes a register ID is about to read.
    always_comb begin
        hz = 1'b0;
        if (id_valid && ex_valid && ex_mem_read && (ex_rd != REG_X0)) begin
            hz = (id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd));
        end
        stall_id = hz && !flush && !reset;
    end

    // Operand select: x0 reads zero, then same-cycle WB bypass, then regfile.
    always_comb begin
        op_a = id_rdata1;
        op_b = id_rdata2;
        if (id_rs1 == REG_X0) begin
            op_a = '0;
        end else if (wb_reg_write && (wb_rd == id_rs1)) begin
            op_a = wb_data;
        end
        if (id_rs2 == REG_X0) begin
            op_b = '0;
        end else if (wb_reg_write && (wb_rd == id_rs2)) begin
            op_b = wb_data;
        end
    end

    // Pipeline register: reset, then flush, then bubble, then normal load.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
        end else if (flush || hz) begin
            // Data fields are held; only the qualifying controls are cleared.
            ex_valid     <= 1'b0;
            ex_ctrl      <= '0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_op_a      <= op_a;
            ex_op_b      <= op_b;
            ex_imm       <= id_imm;
            ex_ctrl      <= id_valid ? id_ctrl : '0;
            ex_mem_read  <= id_valid && id_mem_read;
            ex_reg_write <= id_valid && id_reg_write;
        end
    end

    // Saturating event counters; flush takes precedence over a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (flush) begin
            if (id_valid && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end else if (hz) begin
            if (stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule
